// File: rtl/lc3_control_fsm_pkg.sv
// Shared types and encodings for the LC-3 multicycle control unit.
// Holds the state enum, opcode constants, mux select encodings and the control word.
package lc3_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH0  = 4'd0,
    S_FETCH1  = 4'd1,
    S_FETCH2  = 4'd2,
    S_DECODE  = 4'd3,
    S_ALU     = 4'd4,
    S_BR_CHK  = 4'd5,
    S_BR_TAKE = 4'd6,
    S_JMP     = 4'd7,
    S_ADDR    = 4'd8,
    S_RD      = 4'd9,
    S_WB      = 4'd10,
    S_ST_DATA = 4'd11,
    S_WR      = 4'd12,
    S_HALTED  = 4'd13
  } ctrl_state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_BASER = 1'b1;

  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_OFF6   = 2'b01;
  localparam logic [1:0] ADDR2_PCOFF9 = 2'b10;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_ben;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       mem_en;
    logic       mem_we;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       mio_en;
    logic       halt;
  } ctrl_t;

  function automatic logic is_store(input logic [3:0] opcode);
    return (opcode == OP_ST) || (opcode == OP_STR);
  endfunction

  function automatic logic is_base_rel(input logic [3:0] opcode);
    return (opcode == OP_LDR) || (opcode == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Moore output decode: maps the current state and instruction register to
// the datapath control word. Purely combinational.
module lc3_ctrl_decode
  import lc3_control_fsm_pkg::*;
(
  input  ctrl_state_t state,
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);

  logic [3:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = ir[15:12];
  assign unused_ir_bits = ^ir[11:0];

  always_comb begin
    // NOTE: zero the whole word first so every path assigns every field; no latches.
    ctrl = '0;
    unique case (state)
      S_FETCH0: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_mar  = 1'b1;
        ctrl.ld_pc   = 1'b1;
        ctrl.pcmux   = PCMUX_PC1;
      end
      S_FETCH1, S_RD: begin
        ctrl.mem_en = 1'b1;
        ctrl.mio_en = 1'b1;
        ctrl.ld_mdr = 1'b1;
      end
      S_FETCH2: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_ir    = 1'b1;
      end
      S_DECODE: ctrl.ld_ben = 1'b1;
      S_ALU, S_WB: begin
        ctrl.gate_alu = (state == S_ALU);
        ctrl.gate_mdr = (state == S_WB);
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
      end
      S_BR_TAKE: begin
        ctrl.ld_pc    = 1'b1;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.addr1mux = ADDR1_PC;
        ctrl.addr2mux = ADDR2_PCOFF9;
      end
      S_JMP: begin
        ctrl.ld_pc    = 1'b1;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.addr1mux = ADDR1_BASER;
        ctrl.addr2mux = ADDR2_ZERO;
      end
      S_ADDR: begin
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
        if (is_base_rel(opcode)) begin
          ctrl.addr1mux = ADDR1_BASER;
          ctrl.addr2mux = ADDR2_OFF6;
        end else begin
          ctrl.addr1mux = ADDR1_PC;
          ctrl.addr2mux = ADDR2_PCOFF9;
        end
      end
      // Store data is the source register passed straight through the ALU.
      S_ST_DATA: begin
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
      end
      S_WR: begin
        ctrl.mem_en = 1'b1;
        ctrl.mem_we = 1'b1;
      end
      S_HALTED: ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 multicycle control unit: state register and next-state logic; the
// control word comes from lc3_ctrl_decode and is forced low while in reset.
module lc3_control_fsm
  import lc3_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        ben,
  input  logic        mem_r,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        ld_ben,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        mio_en,
  output logic        halt,
  output logic [3:0]  state
);

  ctrl_state_t state_q, state_nx;
  ctrl_t       ctrl_dec, ctrl;
  logic [3:0]  opcode;

  assign opcode = ir[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!rst_n) state_q <= S_FETCH0;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_FETCH0:  state_nx = S_FETCH1;
      S_FETCH1:  if (mem_r) state_nx = S_FETCH2;
      S_FETCH2:  state_nx = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_ADD, OP_AND, OP_NOT:        state_nx = S_ALU;
          OP_BR:                         state_nx = S_BR_CHK;
          OP_JMP:                        state_nx = S_JMP;
          OP_LD, OP_LDR, OP_ST, OP_STR:  state_nx = S_ADDR;
          default:                       state_nx = S_HALTED;
        endcase
      end
      S_ALU:     state_nx = S_FETCH0;
      // BEN was loaded in DECODE, so it is valid here.
      S_BR_CHK:  state_nx = ben ? S_BR_TAKE : S_FETCH0;
      S_BR_TAKE: state_nx = S_FETCH0;
      S_JMP:     state_nx = S_FETCH0;
      S_ADDR:    state_nx = is_store(opcode) ? S_ST_DATA : S_RD;
      S_RD:      if (mem_r) state_nx = S_WB;
      S_WB:      state_nx = S_FETCH0;
      S_ST_DATA: state_nx = S_WR;
      S_WR:      if (mem_r) state_nx = S_FETCH0;
      S_HALTED:  state_nx = S_HALTED;
      default:   state_nx = S_FETCH0;
    endcase
  end

  lc3_ctrl_decode u_decode (
    .state (state_q),
    .ir    (ir),
    .ctrl  (ctrl_dec)
  );

  // Reset sits in FETCH0, whose decode would assert loads; mask them until release.
  assign ctrl = rst_n ? ctrl_dec : '0;

  assign ld_mar      = ctrl.ld_mar;
  assign ld_mdr      = ctrl.ld_mdr;
  assign ld_ir       = ctrl.ld_ir;
  assign ld_pc       = ctrl.ld_pc;
  assign ld_reg      = ctrl.ld_reg;
  assign ld_cc       = ctrl.ld_cc;
  assign ld_ben      = ctrl.ld_ben;
  assign gate_pc     = ctrl.gate_pc;
  assign gate_mdr    = ctrl.gate_mdr;
  assign gate_alu    = ctrl.gate_alu;
  assign gate_marmux = ctrl.gate_marmux;
  assign mem_en      = ctrl.mem_en;
  assign mem_we      = ctrl.mem_we;
  assign pcmux       = ctrl.pcmux;
  assign addr1mux    = ctrl.addr1mux;
  assign addr2mux    = ctrl.addr2mux;
  assign mio_en      = ctrl.mio_en;
  assign halt        = ctrl.halt;
  assign state       = state_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Self-checking bench for lc3_control_fsm: each instruction is expanded into
// its expected per-cycle step list and every cycle's outputs are compared.
module tb_lc3_control_fsm;
  import lc3_control_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir;
  logic        ben;
  logic        mem_r;
  logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
  logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic        mem_en, mem_we, addr1mux, mio_en, halt;
  logic [1:0]  pcmux, addr2mux;
  logic [3:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ben(ben), .mem_r(mem_r),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc),
    .ld_reg(ld_reg), .ld_cc(ld_cc), .ld_ben(ld_ben),
    .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu),
    .gate_marmux(gate_marmux), .mem_en(mem_en), .mem_we(mem_we),
    .pcmux(pcmux), .addr1mux(addr1mux), .addr2mux(addr2mux),
    .mio_en(mio_en), .halt(halt), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dut_ctrl();
    return {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben,
            gate_pc, gate_mdr, gate_alu, gate_marmux, mem_en, mem_we,
            pcmux, addr1mux, addr2mux, mio_en, halt};
  endfunction

  // Expected control outputs for one step, written from the signal list of each step.
  function automatic logic [19:0] exp_ctrl(input ctrl_state_t s, input logic [3:0] op);
    logic lmar, lmdr, lir, lpc, lreg, lcc, lben, gpc, gmdr, galu, gmm;
    logic men, mwe, a1, mio, hlt;
    logic [1:0] pcm, a2;
    {lmar, lmdr, lir, lpc, lreg, lcc, lben, gpc, gmdr, galu, gmm} = '0;
    {men, mwe, a1, mio, hlt} = '0;
    pcm = 2'b00;
    a2  = 2'b00;
    case (s)
      S_FETCH0:  begin gpc = 1; lmar = 1; lpc = 1; end
      S_FETCH1:  begin men = 1; mio = 1; lmdr = 1; end
      S_FETCH2:  begin gmdr = 1; lir = 1; end
      S_DECODE:  lben = 1;
      S_ALU:     begin galu = 1; lreg = 1; lcc = 1; end
      S_BR_TAKE: begin lpc = 1; pcm = 2'b10; a2 = 2'b10; end
      S_JMP:     begin lpc = 1; pcm = 2'b10; a1 = 1; end
      S_ADDR: begin
        gmm = 1; lmar = 1;
        if (op == 4'b0110 || op == 4'b0111) begin a1 = 1; a2 = 2'b01; end
        else a2 = 2'b10;
      end
      S_RD:      begin men = 1; mio = 1; lmdr = 1; end
      S_WB:      begin gmdr = 1; lreg = 1; lcc = 1; end
      S_ST_DATA: begin galu = 1; lmdr = 1; end
      S_WR:      begin men = 1; mwe = 1; end
      S_HALTED:  hlt = 1;
      default:   ;
    endcase
    return {lmar, lmdr, lir, lpc, lreg, lcc, lben, gpc, gmdr, galu, gmm,
            men, mwe, pcm, a1, a2, mio, hlt};
  endfunction

  task automatic pulse_reset_check(input string name);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'(S_FETCH0) || dut_ctrl() !== 20'h0) begin
      n_fail++;
      $display("FAIL %s in-reset: state=%0d ctrl=%b, want state=%0d ctrl=0", name, state, dut_ctrl(), S_FETCH0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Runs one instruction through the model; stop_after >= 0 halts early at that step.
  task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                           input logic ben_v, input int stop_after);
    ctrl_state_t q[$];
    logic [3:0] op;
    logic [19:0] want;
    op = instr[15:12];
    q.push_back(S_FETCH0);
    for (int k = 0; k <= fw; k++) q.push_back(S_FETCH1);
    q.push_back(S_FETCH2);
    q.push_back(S_DECODE);
    case (op)
      4'b0001, 4'b0101, 4'b1001: q.push_back(S_ALU);
      4'b0000: begin q.push_back(S_BR_CHK); if (ben_v) q.push_back(S_BR_TAKE); end
      4'b1100: q.push_back(S_JMP);
      4'b0010, 4'b0110: begin
        q.push_back(S_ADDR);
        for (int k = 0; k <= mw; k++) q.push_back(S_RD);
        q.push_back(S_WB);
      end
      4'b0011, 4'b0111: begin
        q.push_back(S_ADDR);
        q.push_back(S_ST_DATA);
        for (int k = 0; k <= mw; k++) q.push_back(S_WR);
      end
      default: q.push_back(S_HALTED);
    endcase
    ir = instr;
    for (int i = 0; i < q.size(); i++) begin
      if (stop_after >= 0 && i == stop_after) return;
      want = exp_ctrl(q[i], op);
      n_tests++;
      if (state !== 4'(q[i])) begin
        n_fail++;
        $display("FAIL state ir=%h step %0d: got %0d want %0d", instr, i, state, q[i]);
      end
      n_tests++;
      if (dut_ctrl() !== want) begin
        n_fail++;
        $display("FAIL ctrl ir=%h step %0d: got %b want %b", instr, i, dut_ctrl(), want);
      end
      mem_r = 1'($urandom);
      if (q[i] == S_FETCH1 || q[i] == S_RD || q[i] == S_WR)
        mem_r = (i + 1 < q.size() && q[i+1] == q[i]) ? 1'b0 : 1'b1;
      ben = (q[i] == S_BR_CHK) ? ben_v : 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir    = 16'h1261;
    ben   = 1'b1;
    mem_r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'(S_FETCH0) || dut_ctrl() !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: state=%0d ctrl=%b, want state=0 ctrl=0", state, dut_ctrl());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_add();
    run_instr(16'h1261, 0, 0, 1'b0, -1);
    run_instr(16'h5A3F, 0, 0, 1'b1, -1);
    run_instr(16'h967F, 2, 0, 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr(16'h0E05, 0, 0, 1'b1, -1);
    run_instr(16'h0E05, 0, 0, 1'b0, -1);
    run_instr(16'hC1C0, 1, 0, 1'b1, -1);
  endtask

  task automatic test_load_store();
    run_instr(16'h6443, 0, 4, 1'b0, -1);
    run_instr(16'h2402, 0, 0, 1'b0, -1);
    run_instr(16'h7443, 0, 3, 1'b0, -1);
    run_instr(16'h3402, 1, 0, 1'b1, -1);
  endtask

  task automatic test_halt();
    logic [3:0] ops [8] = '{4'hF, 4'h4, 4'h8, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
    for (int k = 0; k < 8; k++) begin
      run_instr((k == 0) ? 16'hF025 : {ops[k], 12'($urandom)}, 0, 0, 1'b0, -1);
      for (int c = 0; c < 6; c++) begin
        n_tests++;
        if (state !== 4'(S_HALTED) || dut_ctrl() !== exp_ctrl(S_HALTED, ops[k])) begin
          n_fail++;
          $display("FAIL halt-hold op=%h cycle %0d: state=%0d ctrl=%b want state=%0d halt only", ops[k], c, state, dut_ctrl(), S_HALTED);
        end
        mem_r = 1'($urandom);
        ben   = 1'($urandom);
        ir    = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        #1;
      end
      pulse_reset_check("halt-exit");
    end
  endtask

  task automatic test_reset_mid_wr();
    run_instr(16'h7443, 0, 3, 1'b0, 7);
    n_tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr-wait: mem_en=%b mem_we=%b want 1 1", mem_en, mem_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0 || state !== 4'(S_FETCH0)) begin
      n_fail++;
      $display("FAIL async-reset-wr: mem_en=%b mem_we=%b state=%0d want 0 0 %0d", mem_en, mem_we, state, S_FETCH0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_instr(16'h1261, 0, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [3:0] legal [9] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h2, 4'h6, 4'h3, 4'h7};
    for (int k = 0; k < 40; k++) begin
      run_instr({legal[$urandom_range(8)], 12'($urandom)}, int'($urandom_range(2)),
                int'($urandom_range(3)), 1'($urandom), -1);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(16'h0E05, 0, 0, 1'b0, -1);
    run_instr(16'h6443, 0, 0, 1'b0, -1);
    run_instr(16'h7443, 0, 0, 1'b0, -1);
    run_instr(16'hC1C0, 0, 0, 1'b0, -1);
    run_instr(16'h1261, 0, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_store();
    test_back_to_back();
    test_reset_mid_wr();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
